// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types: datapath widths, fetch FSM states and the
// {pc, instruction} record carried through the prefetch queue.
package legv8_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_HALT,
    FS_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and the decode
// valid/ready handshake. master is the fetch stage, slave is its environment.
interface instruction_fetch_stage_if;
  import legv8_pkg::*;

  logic [ADDR_W-1:0]  FETCH_PC;
  logic [INSTR_W-1:0] CPU_Instruction;
  logic               REDIRECT_VALID;
  logic [ADDR_W-1:0]  REDIRECT_PC;
  logic               ID_READY;
  logic               ID_VALID;
  logic [ADDR_W-1:0]  ID_PC;
  logic [INSTR_W-1:0] ID_INSTRUCTION;

  modport master (
    output FETCH_PC,
    input  CPU_Instruction,
    input  REDIRECT_VALID,
    input  REDIRECT_PC,
    input  ID_READY,
    output ID_VALID,
    output ID_PC,
    output ID_INSTRUCTION
  );

  modport slave (
    input  FETCH_PC,
    output CPU_Instruction,
    output REDIRECT_VALID,
    output REDIRECT_PC,
    output ID_READY,
    input  ID_VALID,
    input  ID_PC,
    input  ID_INSTRUCTION
  );

endinterface

// File: rtl/instruction_fetch_stage_fetch_queue.sv
// In-order FIFO of fetch entries with synchronous clear; a push into a full
// queue is accepted only when a pop happens on the same edge.
module fetch_queue
  import legv8_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  fetch_entry_t  pushEntry_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          pushOk, popOk;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pushOk  = push_i & (~full_o | pop_i);
  assign popOk   = pop_i & ~empty_o;
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushEntry_i;
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (popOk) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      unique case ({pushOk, popOk})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// LEGv8 fetch front end: owns the PC, fetches from combinational instruction
// memory into a prefetch queue and serves decode; redirects flush the queue.
module instruction_fetch_stage
  import legv8_pkg::*;
#(
  parameter int unsigned       QUEUE_DEPTH = 2,
  parameter int unsigned       MEM_BYTES   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0
) (
  input  logic                      CLOCK,
  input  logic                      RESET_N,
  instruction_fetch_stage_if.master bus,
  output logic                      HALTED,
  output logic                      FETCH_FAULT
);

  localparam int unsigned       CW        = $clog2(QUEUE_DEPTH + 1);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pcNext;
  logic              popFire, pushFire, redirectTake;
  fetch_entry_t      headEntry, pushEntry;
  logic [CW-1:0]     queueCount;
  logic              queueEmpty, queueFull;

  assign pcNext       = pc_q + ADDR_W'(PC_INCR);
  assign popFire      = bus.ID_VALID & bus.ID_READY;
  assign redirectTake = bus.REDIRECT_VALID & (state_q != FS_FAULT);
  assign pushFire     = (state_q == FS_RUN) & ~bus.REDIRECT_VALID & (~queueFull | popFire);
  assign pushEntry    = '{pc: pc_q, instruction: bus.CPU_Instruction};

  // Outside RUN the memory address is parked at 0 so it is never out of range.
  assign bus.FETCH_PC       = (state_q == FS_RUN) ? pc_q : '0;
  assign bus.ID_VALID       = ~queueEmpty;
  assign bus.ID_PC          = headEntry.pc;
  assign bus.ID_INSTRUCTION = headEntry.instruction;
  assign HALTED             = (state_q == FS_HALT) & (queueCount == '0);
  assign FETCH_FAULT        = (state_q == FS_FAULT);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else if (redirectTake) begin
      pc_q <= bus.REDIRECT_PC;
      if (bus.REDIRECT_PC[1:0] != 2'b00) begin
        state_q <= FS_FAULT;
      end else if (bus.REDIRECT_PC >= MEM_LIMIT) begin
        state_q <= FS_HALT;
      end else begin
        state_q <= FS_RUN;
      end
    end else if (pushFire) begin
      pc_q <= pcNext;
      if (pcNext >= MEM_LIMIT) begin
        state_q <= FS_HALT;
      end
    end
  end

  // A redirect clear also swallows any pop decode attempted on that edge.
  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (CLOCK),
    .rst_ni      (RESET_N),
    .clear_i     (redirectTake),
    .push_i      (pushFire),
    .pushEntry_i (pushEntry),
    .pop_i       (popFire & ~redirectTake),
    .head_o      (headEntry),
    .count_o     (queueCount),
    .empty_o     (queueEmpty),
    .full_o      (queueFull)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a 64-byte big-endian
// instruction memory model whose contents are defined by instrAt().
module tb_instruction_fetch_stage;
  import legv8_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b1;
  logic HALTED;
  logic FETCH_FAULT;
  int   testCount = 0;
  int   failCount = 0;

  logic [7:0] imem [64];
  logic [5:0] byteAddr;

  instruction_fetch_stage_if busIf ();

  instruction_fetch_stage #(
    .QUEUE_DEPTH(2),
    .MEM_BYTES  (64),
    .RESET_PC   (64'h0)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .bus        (busIf),
    .HALTED     (HALTED),
    .FETCH_FAULT(FETCH_FAULT)
  );

  always #5 CLOCK = ~CLOCK;

  assign byteAddr = busIf.FETCH_PC[5:0];
  assign busIf.CPU_Instruction = {imem[byteAddr], imem[byteAddr + 6'd1],
                                  imem[byteAddr + 6'd2], imem[byteAddr + 6'd3]};

  function automatic logic [31:0] instrAt(input logic [63:0] pc);
    case (pc[5:2])
      4'd0:    return 32'hF84083E1;
      4'd1:    return 32'hF84103E2;
      4'd2:    return 32'hF84183E3;
      4'd12:   return 32'h8B030022;
      4'd13:   return 32'hCB0400A6;
      4'd15:   return 32'h8A0B014C;
      default: return 32'h91000400 | {28'd0, pc[5:2]};
    endcase
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    busIf.ID_READY = 1'b1;
    busIf.REDIRECT_VALID = 1'b0;
    busIf.REDIRECT_PC = '0;
    #2 RESET_N = 1'b0;
    #1;
    testCount++;
    if (busIf.ID_VALID !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_id_valid actual=%0b required=0", busIf.ID_VALID);
    end
    testCount++;
    if (busIf.ID_PC !== 64'h0 || busIf.ID_INSTRUCTION !== 32'h0) begin
      failCount++; $display("[TB] FAIL reset_id_outputs actual=%h/%h required=0/0", busIf.ID_PC, busIf.ID_INSTRUCTION);
    end
    testCount++;
    if (HALTED !== 1'b0 || FETCH_FAULT !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_status actual=%0b/%0b required=0/0", HALTED, FETCH_FAULT);
    end
    testCount++;
    if (busIf.FETCH_PC !== 64'h0) begin
      failCount++; $display("[TB] FAIL reset_fetch_pc actual=%h required=0", busIf.FETCH_PC);
    end
  endtask

  task automatic test_stream();
    logic [63:0] expPc;
    tick();
    RESET_N = 1'b1;
    testCount++;
    if (busIf.ID_VALID !== 1'b0) begin
      failCount++; $display("[TB] FAIL stream_pre_valid actual=%0b required=0", busIf.ID_VALID);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      expPc = 64'(i * 4);
      testCount++;
      if (busIf.ID_VALID !== 1'b1 || busIf.ID_PC !== expPc || busIf.ID_INSTRUCTION !== instrAt(expPc)) begin
        failCount++;
        $display("[TB] FAIL stream_head%0d actual=%0b/%h/%h required=1/%h/%h", i,
                 busIf.ID_VALID, busIf.ID_PC, busIf.ID_INSTRUCTION, expPc, instrAt(expPc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] expPc;
    RESET_N = 1'b0;
    busIf.ID_READY = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    tick();
    testCount++;
    if (busIf.FETCH_PC !== 64'h8) begin
      failCount++; $display("[TB] FAIL bp_fetch_hold actual=%h required=8", busIf.FETCH_PC);
    end
    busIf.ID_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expPc = 64'(i * 4);
      testCount++;
      if (busIf.ID_VALID !== 1'b1 || busIf.ID_PC !== expPc || busIf.ID_INSTRUCTION !== instrAt(expPc)) begin
        failCount++;
        $display("[TB] FAIL bp_head%0d actual=%0b/%h/%h required=1/%h/%h", i,
                 busIf.ID_VALID, busIf.ID_PC, busIf.ID_INSTRUCTION, expPc, instrAt(expPc));
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    busIf.ID_READY = 1'b0;
    busIf.REDIRECT_VALID = 1'b1;
    busIf.REDIRECT_PC = 64'h10;
    tick();
    busIf.REDIRECT_VALID = 1'b0;
    tick();
    tick();
    tick();
    testCount++;
    if (busIf.ID_PC !== 64'h10 || busIf.ID_INSTRUCTION !== instrAt(64'h10) || busIf.FETCH_PC !== 64'h18) begin
      failCount++;
      $display("[TB] FAIL redir_full_state actual=%h/%h/%h required=10/%h/18",
               busIf.ID_PC, busIf.ID_INSTRUCTION, busIf.FETCH_PC, instrAt(64'h10));
    end
    busIf.ID_READY = 1'b1;
    busIf.REDIRECT_VALID = 1'b1;
    busIf.REDIRECT_PC = 64'h30;
    tick();
    busIf.REDIRECT_VALID = 1'b0;
    testCount++;
    if (busIf.ID_VALID !== 1'b0) begin
      failCount++; $display("[TB] FAIL redir_flush actual=%0b required=0", busIf.ID_VALID);
    end
    tick();
    testCount++;
    if (busIf.ID_VALID !== 1'b1 || busIf.ID_PC !== 64'h30 || busIf.ID_INSTRUCTION !== 32'h8B030022) begin
      failCount++;
      $display("[TB] FAIL redir_head30 actual=%0b/%h/%h required=1/30/8b030022",
               busIf.ID_VALID, busIf.ID_PC, busIf.ID_INSTRUCTION);
    end
    tick();
    testCount++;
    if (busIf.ID_VALID !== 1'b1 || busIf.ID_PC !== 64'h34 || busIf.ID_INSTRUCTION !== 32'hCB0400A6) begin
      failCount++;
      $display("[TB] FAIL redir_head34 actual=%0b/%h/%h required=1/34/cb0400a6",
               busIf.ID_VALID, busIf.ID_PC, busIf.ID_INSTRUCTION);
    end
  endtask

  task automatic test_run_to_end();
    tick();
    tick();
    testCount++;
    if (busIf.ID_PC !== 64'h3C || busIf.ID_INSTRUCTION !== 32'h8A0B014C || busIf.FETCH_PC !== 64'h0 || HALTED !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL end_last_entry actual=%h/%h/%h/%0b required=3c/8a0b014c/0/0",
               busIf.ID_PC, busIf.ID_INSTRUCTION, busIf.FETCH_PC, HALTED);
    end
    tick();
    testCount++;
    if (HALTED !== 1'b1 || busIf.ID_VALID !== 1'b0 || busIf.FETCH_PC !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL end_halted actual=%0b/%0b/%h required=1/0/0", HALTED, busIf.ID_VALID, busIf.FETCH_PC);
    end
    busIf.REDIRECT_VALID = 1'b1;
    busIf.REDIRECT_PC = 64'h0;
    tick();
    busIf.REDIRECT_VALID = 1'b0;
    testCount++;
    if (HALTED !== 1'b0) begin
      failCount++; $display("[TB] FAIL end_unhalt actual=%0b required=0", HALTED);
    end
    tick();
    testCount++;
    if (busIf.ID_VALID !== 1'b1 || busIf.ID_PC !== 64'h0 || busIf.ID_INSTRUCTION !== 32'hF84083E1) begin
      failCount++;
      $display("[TB] FAIL end_restart actual=%0b/%h/%h required=1/0/f84083e1",
               busIf.ID_VALID, busIf.ID_PC, busIf.ID_INSTRUCTION);
    end
  endtask

  task automatic test_fault();
    busIf.REDIRECT_VALID = 1'b1;
    busIf.REDIRECT_PC = 64'h2;
    tick();
    busIf.REDIRECT_VALID = 1'b0;
    testCount++;
    if (FETCH_FAULT !== 1'b1 || busIf.ID_VALID !== 1'b0) begin
      failCount++; $display("[TB] FAIL fault_entry actual=%0b/%0b required=1/0", FETCH_FAULT, busIf.ID_VALID);
    end
    tick();
    tick();
    testCount++;
    if (busIf.ID_VALID !== 1'b0 || busIf.FETCH_PC !== 64'h0) begin
      failCount++; $display("[TB] FAIL fault_idle actual=%0b/%h required=0/0", busIf.ID_VALID, busIf.FETCH_PC);
    end
    busIf.REDIRECT_VALID = 1'b1;
    busIf.REDIRECT_PC = 64'h0;
    tick();
    busIf.REDIRECT_VALID = 1'b0;
    tick();
    tick();
    testCount++;
    if (FETCH_FAULT !== 1'b1 || busIf.ID_VALID !== 1'b0) begin
      failCount++; $display("[TB] FAIL fault_sticky actual=%0b/%0b required=1/0", FETCH_FAULT, busIf.ID_VALID);
    end
    RESET_N = 1'b0;
    #1;
    testCount++;
    if (FETCH_FAULT !== 1'b0) begin
      failCount++; $display("[TB] FAIL fault_reset_clear actual=%0b required=0", FETCH_FAULT);
    end
  endtask

  task automatic test_async_reset();
    busIf.ID_READY = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    testCount++;
    if (busIf.ID_VALID !== 1'b1 || busIf.FETCH_PC !== 64'h8) begin
      failCount++; $display("[TB] FAIL areset_full actual=%0b/%h required=1/8", busIf.ID_VALID, busIf.FETCH_PC);
    end
    #3 RESET_N = 1'b0;
    #1;
    testCount++;
    if (busIf.ID_VALID !== 1'b0 || HALTED !== 1'b0 || FETCH_FAULT !== 1'b0 || busIf.ID_PC !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL areset_drop actual=%0b/%0b/%0b/%h required=0/0/0/0",
               busIf.ID_VALID, HALTED, FETCH_FAULT, busIf.ID_PC);
    end
    tick();
    RESET_N = 1'b1;
    busIf.ID_READY = 1'b1;
    tick();
    testCount++;
    if (busIf.ID_VALID !== 1'b1 || busIf.ID_PC !== 64'h0 || busIf.ID_INSTRUCTION !== 32'hF84083E1) begin
      failCount++;
      $display("[TB] FAIL areset_first_head actual=%0b/%h/%h required=1/0/f84083e1",
               busIf.ID_VALID, busIf.ID_PC, busIf.ID_INSTRUCTION);
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int a = 0; a < 64; a += 4) begin
      w = instrAt(64'(a));
      imem[a]     = w[31:24];
      imem[a + 1] = w[23:16];
      imem[a + 2] = w[15:8];
      imem[a + 3] = w[7:0];
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_run_to_end();
    test_fault();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
